// File: rtl/off_chip_rx_link.sv
// Purpose : receive side of the off-chip token link; buffers lock-stepped io beats and reassembles core words.
// Latency : beat sampled at edge t is popped at edge t+1; a word's last beat sampled at t shows valid after t+1.
// Backpr. : core_ready low holds the word and lets the FIFO fill; credit returns as io_token_out toggles.
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   io_valid_in       beat present on io_data_in (channel c at [c*CH_W +: CH_W])
//   io_token_out      toggles once per TOKEN_BATCH beats popped from the FIFO
//   core_data_out     reassembled word, beat 0 in the LSBs
//   core_valid_out    word held valid until core_ready accepts it
//   core_ready        core accepts the word when valid & ready
//   fifo_count        beats currently buffered (0..DEPTH)
//   overflow_err      sticky: a beat arrived while the FIFO was full and nothing popped

module off_chip_rx_link #(
   parameter int CHANNELS    = 2,
   parameter int CH_W        = 8,
   parameter int BEATS       = 4,
   parameter int DEPTH       = 8,
   parameter int TOKEN_BATCH = 2
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            io_valid_in,
   input  logic [CHANNELS*CH_W-1:0]        io_data_in,
   output logic                            io_token_out,
   output logic [CHANNELS*CH_W*BEATS-1:0]  core_data_out,
   output logic                            core_valid_out,
   input  logic                            core_ready,
   output logic [$clog2(DEPTH+1)-1:0]      fifo_count,
   output logic                            overflow_err
);

   localparam int BW    = CHANNELS * CH_W;
   localparam int PTR_W = $clog2(DEPTH);
   // DEPTH is a power of two, so an extra wrap bit on each pointer makes
   // wr_ptr - rd_ptr the exact occupancy 0..DEPTH.
   localparam int CNT_W = PTR_W + 1;
   localparam int K_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int TC_W  = (TOKEN_BATCH > 1) ? $clog2(TOKEN_BATCH) : 1;

   typedef enum logic {
      FILL = 1'b0,   // collecting beats of the next word
      HOLD = 1'b1    // complete word presented to the core
   } asm_state_t;

   // ------------------------------------------------------------------
   // Beat FIFO
   // ------------------------------------------------------------------
   logic [BW-1:0]    mem [DEPTH];
   logic [PTR_W:0]   wr_ptr;
   logic [PTR_W:0]   rd_ptr;
   logic [CNT_W-1:0] occ;
   logic             full;
   logic             empty;
   logic             wr_en;
   logic             pop;
   logic [BW-1:0]    rd_dat;

   assign occ        = wr_ptr - rd_ptr;
   assign full       = (occ == CNT_W'(DEPTH));
   assign empty      = (occ == '0);
   assign fifo_count = occ;
   assign rd_dat     = mem[rd_ptr[PTR_W-1:0]];

   // A pop in the same cycle frees the slot the incoming beat needs, so a
   // full FIFO still accepts a write when the assembler is draining it.
   assign wr_en = io_valid_in && (!full || pop);

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr[PTR_W-1:0]] <= io_data_in;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         overflow_err <= 1'b0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + (PTR_W+1)'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + (PTR_W+1)'(1);
         end
         if (io_valid_in && full && !pop) begin
            overflow_err <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Word assembler
   // ------------------------------------------------------------------
   asm_state_t     state_q;
   asm_state_t     state_d;
   logic [K_W-1:0] k_q;
   logic [K_W-1:0] k_d;
   logic [K_W-1:0] slot;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= FILL;
         k_q     <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
      end
   end

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      pop     = 1'b0;
      slot    = k_q;
      case (state_q)
         FILL: begin
            pop = !empty;
            if (pop) begin
               if (k_q == K_W'(BEATS-1)) begin
                  state_d = HOLD;
                  k_d     = '0;
               end else begin
                  k_d = k_q + K_W'(1);
               end
            end
         end
         HOLD: begin
            // While holding, only an accepting cycle may pop; the popped beat
            // becomes slot 0 of the next word so throughput stays 1 beat/cycle.
            slot = '0;
            pop  = !empty && core_ready;
            if (core_ready) begin
               if (pop) begin
                  if (BEATS == 1) begin
                     state_d = HOLD;
                     k_d     = '0;
                  end else begin
                     state_d = FILL;
                     k_d     = K_W'(1);
                  end
               end else begin
                  state_d = FILL;
                  k_d     = '0;
               end
            end
         end
         default: begin
            state_d = FILL;
            k_d     = '0;
         end
      endcase
   end

   assign core_valid_out = (state_q == HOLD);

   // Slots are only written on a pop, and a HOLD-state pop requires
   // core_ready, so the presented word cannot change before acceptance.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         core_data_out <= '0;
      end else if (pop) begin
         for (int b = 0; b < BEATS; b++) begin
            if (slot == K_W'(b)) begin
               core_data_out[b*BW +: BW] <= rd_dat;
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Credit return
   // ------------------------------------------------------------------
   logic [TC_W-1:0] tok_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tok_cnt      <= '0;
         io_token_out <= 1'b0;
      end else if (pop) begin
         if (tok_cnt == TC_W'(TOKEN_BATCH-1)) begin
            tok_cnt      <= '0;
            io_token_out <= ~io_token_out;
         end else begin
            tok_cnt <= tok_cnt + TC_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_off_chip_rx_link.sv
// Bench for off_chip_rx_link: default configuration plus a 4x8-bit, 1-beat,
// depth-4, batch-1 configuration, checked against a queue-based model.

module tb_off_chip_rx_link;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;

   // default configuration
   logic        io_valid_in;
   logic [15:0] io_data_in;
   logic        io_token_out;
   logic [63:0] core_data_out;
   logic        core_valid_out;
   logic        core_ready;
   logic [3:0]  fifo_count;
   logic        overflow_err;

   // CHANNELS=4 CH_W=8 BEATS=1 DEPTH=4 TOKEN_BATCH=1
   logic        v5;
   logic [31:0] d5;
   logic        tok5;
   logic [31:0] data5;
   logic        vld5;
   logic        rdy5;
   logic [2:0]  cnt5;
   logic        ovf5;

   off_chip_rx_link u_dut (
      .clk            (clk),
      .rst            (rst),
      .io_valid_in    (io_valid_in),
      .io_data_in     (io_data_in),
      .io_token_out   (io_token_out),
      .core_data_out  (core_data_out),
      .core_valid_out (core_valid_out),
      .core_ready     (core_ready),
      .fifo_count     (fifo_count),
      .overflow_err   (overflow_err)
   );

   off_chip_rx_link #(
      .CHANNELS(4), .CH_W(8), .BEATS(1), .DEPTH(4), .TOKEN_BATCH(1)
   ) u_dut5 (
      .clk            (clk),
      .rst            (rst),
      .io_valid_in    (v5),
      .io_data_in     (d5),
      .io_token_out   (tok5),
      .core_data_out  (data5),
      .core_valid_out (vld5),
      .core_ready     (rdy5),
      .fifo_count     (cnt5),
      .overflow_err   (ovf5)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Token toggle counters and accepted-word capture, sampled on the falling edge.
   int   tog_cnt   = 0;
   int   tog5_cnt  = 0;
   logic tok_prev  = 1'b0;
   logic tok5_prev = 1'b0;
   logic [63:0] acc_q[$];
   logic [31:0] acc5_q[$];

   always @(negedge clk or negedge rst) begin
      if (!rst) begin
         tok_prev  = 1'b0;
         tok5_prev = 1'b0;
      end else begin
         if (io_token_out !== tok_prev) begin
            tog_cnt++;
            tok_prev = io_token_out;
         end
         if (tok5 !== tok5_prev) begin
            tog5_cnt++;
            tok5_prev = tok5;
         end
         if (core_valid_out && core_ready) acc_q.push_back(core_data_out);
         if (vld5 && rdy5) acc5_q.push_back(data5);
      end
   end

   task automatic cyc(input logic v, input logic [15:0] d);
      @(posedge clk);
      #1;
      io_valid_in = v;
      io_data_in  = d;
   endtask

   logic [15:0] bt [16];
   logic [31:0] exp5_q[$];
   logic [15:0] exp_q[$];
   int          t0;
   int          sent;
   int          credits;
   logic [63:0] w;

   initial begin
      rst = 1'b0; io_valid_in = 1'b0; io_data_in = '0; core_ready = 1'b0;
      v5 = 1'b0; d5 = '0; rdy5 = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_cnt",   fifo_count, 0);
      chk("rst_vld",   core_valid_out, 0);
      chk("rst_data",  core_data_out, 0);
      chk("rst_tok",   io_token_out, 0);
      chk("rst_ovf",   overflow_err, 0);
      chk("rst_vld5",  vld5, 0);
      @(posedge clk); #1 rst = 1'b1;

      // ---- 1: four beats, core ready ----
      core_ready = 1'b1;
      bt[0] = 16'h1100; bt[1] = 16'h3322; bt[2] = 16'h5544; bt[3] = 16'h7766;
      t0 = tog_cnt;
      acc_q.delete();
      for (int i = 0; i < 4; i++) cyc(1'b1, bt[i]);
      cyc(1'b0, 16'h0);
      @(negedge clk);
      chk("t1_vld_early", core_valid_out, 0);
      chk("t1_tok_mid",   io_token_out, 1);
      @(negedge clk);
      chk("t1_vld",  core_valid_out, 1);
      chk("t1_data", core_data_out, 64'h7766_5544_3322_1100);
      @(negedge clk);
      chk("t1_vld_drop", core_valid_out, 0);
      @(negedge clk);
      chk("t1_toggles", tog_cnt - t0, 2);
      chk("t1_tok",     io_token_out, 0);
      chk("t1_nacc",    acc_q.size(), 1);

      // ---- 2: core stalled, 12 beats fill, 13th overflows ----
      core_ready = 1'b0;
      acc_q.delete();
      t0 = tog_cnt;
      for (int i = 0; i < 13; i++) bt[i] = 16'($urandom);
      for (int i = 0; i < 12; i++) cyc(1'b1, bt[i]);
      cyc(1'b1, 16'hBAD0);
      @(negedge clk);
      chk("t2_cnt",  fifo_count, 8);
      chk("t2_ovf0", overflow_err, 0);
      chk("t2_vld",  core_valid_out, 1);
      chk("t2_data", core_data_out, {bt[3], bt[2], bt[1], bt[0]});
      cyc(1'b0, 16'h0);
      @(negedge clk);
      chk("t2_ovf1", overflow_err, 1);
      chk("t2_cnt_full", fifo_count, 8);
      @(negedge clk);
      chk("t2_toggles", tog_cnt - t0, 2);

      // ---- 3: accept and write together at full ----
      @(posedge clk); #1;
      core_ready = 1'b1; io_valid_in = 1'b1; io_data_in = bt[12];
      @(posedge clk); #1;
      core_ready = 1'b0; io_valid_in = 1'b0;
      @(negedge clk);
      chk("t3_cnt",  fifo_count, 8);
      chk("t3_vld0", core_valid_out, 0);
      chk("t3_nacc", acc_q.size(), 1);
      chk("t3_acc0", acc_q[0], {bt[3], bt[2], bt[1], bt[0]});
      repeat (3) @(negedge clk);
      chk("t3_vld",  core_valid_out, 1);
      chk("t3_data", core_data_out, {bt[7], bt[6], bt[5], bt[4]});
      chk("t3_cnt5", fifo_count, 5);
      @(posedge clk); #1 core_ready = 1'b1;
      repeat (12) @(negedge clk);
      chk("t3_nacc3", acc_q.size(), 3);
      chk("t3_acc1",  acc_q[1], {bt[7], bt[6], bt[5], bt[4]});
      chk("t3_acc2",  acc_q[2], {bt[11], bt[10], bt[9], bt[8]});
      chk("t3_empty", fifo_count, 0);
      chk("t3_ovf_sticky", overflow_err, 1);

      // ---- 4: reset while a word is held and beats are queued ----
      core_ready = 1'b0;
      for (int i = 0; i < 4; i++) cyc(1'b1, 16'($urandom));
      cyc(1'b0, 16'h0);
      @(negedge clk);
      chk("t4_pre_vld", core_valid_out, 1);
      chk("t4_pre_cnt", fifo_count, 1);
      @(posedge clk); #3 rst = 1'b0;
      #1;
      chk("t4_rst_vld",  core_valid_out, 0);
      chk("t4_rst_cnt",  fifo_count, 0);
      chk("t4_rst_tok",  io_token_out, 0);
      chk("t4_rst_data", core_data_out, 0);
      chk("t4_rst_ovf",  overflow_err, 0);
      @(posedge clk); #1 rst = 1'b1;
      acc_q.delete();
      core_ready = 1'b1;
      for (int i = 0; i < 4; i++) bt[i] = 16'($urandom);
      for (int i = 0; i < 4; i++) cyc(1'b1, bt[i]);
      cyc(1'b0, 16'h0);
      repeat (6) @(negedge clk);
      chk("t4_nacc", acc_q.size(), 1);
      chk("t4_word", acc_q[0], {bt[3], bt[2], bt[1], bt[0]});

      // ---- 5: single-beat words, batch 1 ----
      rdy5 = 1'b1;
      t0 = tog5_cnt;
      @(posedge clk); #1 v5 = 1'b1; d5 = 32'hDEADBEEF;
      @(posedge clk); #1 v5 = 1'b0;
      @(negedge clk);
      chk("t5_vld_early", vld5, 0);
      @(negedge clk);
      chk("t5_vld",  vld5, 1);
      chk("t5_data", data5, 32'hDEADBEEF);
      @(negedge clk);
      chk("t5_vld_drop", vld5, 0);
      chk("t5_tog1", tog5_cnt - t0, 1);
      acc5_q.delete();
      t0 = tog5_cnt;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         v5 = 1'b1; d5 = $urandom;
         exp5_q.push_back(d5);
      end
      @(posedge clk); #1 v5 = 1'b0;
      repeat (6) @(negedge clk);
      chk("t5_nacc", acc5_q.size(), 6);
      for (int i = 0; i < 6 && i < acc5_q.size(); i++) chk("t5_word", acc5_q[i], exp5_q[i]);
      chk("t5_toggles", tog5_cnt - t0, 6);
      chk("t5_ovf", ovf5, 0);

      // ---- 6: random traffic, sender obeys credit ----
      @(posedge clk); #3 rst = 1'b0;
      @(posedge clk); #1 rst = 1'b1;
      acc_q.delete();
      exp_q.delete();
      sent = 0;
      t0 = tog_cnt;
      for (int c = 0; c < 10000; c++) begin
         @(posedge clk); #1;
         credits = 8 - sent + 2 * (tog_cnt - t0);
         if (credits > 0 && $urandom_range(0, 3) != 0 && (c < 9900 || (sent % 4) != 0)) begin
            io_valid_in = 1'b1;
            io_data_in  = 16'($urandom);
            exp_q.push_back(io_data_in);
            sent++;
         end else begin
            io_valid_in = 1'b0;
         end
         core_ready = ($urandom_range(0, 3) < 2);
      end
      @(posedge clk); #1 io_valid_in = 1'b0; core_ready = 1'b1;
      repeat (40) @(negedge clk);
      chk("t6_ovf",     overflow_err, 0);
      chk("t6_empty",   fifo_count, 0);
      chk("t6_vld",     core_valid_out, 0);
      chk("t6_nwords",  acc_q.size(), sent / 4);
      chk("t6_toggles", tog_cnt - t0, sent / 2);
      for (int i = 0; i < acc_q.size() && exp_q.size() >= 4; i++) begin
         w = '0;
         for (int b = 0; b < 4; b++) w[b*16 +: 16] = exp_q.pop_front();
         chk("t6_word", acc_q[i], w);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
